sumador_control: RTL
====================

Name: sumador_control

Overview:
- Sequencing controller between the matrix-keypad scanner and the adder/display datapath of the FPGA adder.
- Turns keypad codes into two BCD operands, then runs a digit-serial BCD addition.
- Exposes operands, result and a display-select code for the 7-segment driver.

Parameters:
NDIG, 3, BCD digits per operand (1..8); result has NDIG+1 digits

Ports:
clk  input  1  system clock (27 MHz)
rst  input  1  reset, synchronous, active-low
key_code  input  4  keypad code, valid while key_pressed=1
key_pressed  input  1  level; 1 while a key is held
digits_a  output  4*NDIG  operand A, BCD, digit 0 in [3:0]
digits_b  output  4*NDIG  operand B, BCD
result  output  4*(NDIG+1)  sum, BCD
result_valid  output  1  1 while result is final
busy  output  1  1 during CALC
disp_sel  output  2  0=show A, 1=show B, 2=show result
state_o  output  2  current FSM state encoding

Behaviour:
- Reset: rst=0 sampled at posedge clk. All outputs and counters clear to 0; state ENTER_A. Reset overrides any simultaneous event, including mid-CALC.
- Key event: key_evt = key_pressed & ~key_pressed_q, where key_pressed_q is the registered previous sample. key_code is sampled in the same cycle. A held key gives exactly one event. Events not accepted are dropped, never queued.
- Key map: 0-9 digit, A add, B equals, C clear, D backspace (optional feature), E/F ignored in all states.
- States ENTER_A(0), ENTER_B(1), CALC(2), RESULT(3). disp_sel is 0/1/1/2 respectively.
- ENTER_A, digit key:
  - If cnt_a==0 and the digit is 0: ignored (no leading zeros).
  - Else if cnt_a<NDIG: A shifts left one digit, new digit enters digit 0, cnt_a+1.
  - Else (full): ignored.
- ENTER_A, other keys: A -> ENTER_B. B ignored.
- ENTER_B, digit key: same rules applied to B and cnt_b.
- ENTER_B, other keys: B -> CALC with digit index=0 and carry=0. A ignored.
- C in ENTER_A, ENTER_B or RESULT: clears A, B, result, counters and result_valid; state ENTER_A.
- CALC timing: equals edge sampled at cycle t, so state=CALC and busy=1 from t+1.
- CALC per cycle i (t+1..t+NDIG):
  - s = a_i + b_i + carry.
  - If s>9: result digit i = s-10, carry=1. Else result digit i = s, carry=0.
- CALC completion: at t+NDIG+1, result top digit = carry, state=RESULT, result_valid=1, busy=0. All key events during CALC are ignored.
- RESULT, digit key: clears everything, then loads that digit as the first digit of A (cnt_a=1; a 0 digit is dropped). State ENTER_A.
- RESULT, A and B keys: ignored.
- A and B operands hold their values through CALC and RESULT.

Optional Feature:
- SUMADOR_BACKSPACE_EN defined:
  - Key D in ENTER_A/ENTER_B with count>0 shifts the active operand right one digit (top digit becomes 0) and decrements its count.
  - D with count==0 is ignored; D in CALC/RESULT is ignored.
- Not defined: D is ignored everywhere, same as E/F.

Decomposition:
- Package sumador_pkg:
  - state_t enum (ENTER_A, ENTER_B, CALC, RESULT).
  - Key constants KEY_ADD=4'hA, KEY_EQ=4'hB, KEY_CLR=4'hC, KEY_BKSP=4'hD.
  - Function is_digit(code).
- Sub-module bcd_digit_add: combinational; inputs a[3:0], b[3:0], cin; outputs s[3:0], cout. Instantiated once and muxed by digit index.

Test Plan (NDIG=3):
- Keys 1,2,3,A,4,5,6,B, each held 5 cycles with 5 idle cycles between -> digits_a=12'h123, digits_b=12'h456; result=16'h0579 and result_valid exactly 4 cycles after the B edge; busy high for 3 cycles.
- 9,9,9,A,9,9,9,B -> result=16'h1998 (carry ripples into top digit).
- 0,0,1,2,3,4 into A -> digits_a=12'h123 (leading zeros and 4th digit ignored).
- Key 7 held 200 cycles -> digits_a=12'h007. Keys pressed during CALC -> no change. In RESULT, key 5 -> all cleared, digits_a=12'h005, state ENTER_A.
- C during ENTER_B with A=0x012 -> all outputs 0, state ENTER_A. rst=0 for one cycle mid-CALC -> all outputs 0 at the next edge.
- 1,2,D: with SUMADOR_BACKSPACE_EN -> digits_a=12'h001; without it -> digits_a=12'h012.

Source files
------------

// File: rtl/sumador_pkg.sv
// sumador_pkg: shared types and constants for the keypad adder controller.
//   state_t   - controller state encoding (also exported on state_o)
//   KEY_*     - keypad codes with a control meaning
//   is_digit  - true for keypad codes 0..9
package sumador_pkg;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        CALC    = 2'd2,
        RESULT  = 2'd3
    } state_t;

    localparam logic [3:0] KEY_ADD  = 4'hA;
    localparam logic [3:0] KEY_EQ   = 4'hB;
    localparam logic [3:0] KEY_CLR  = 4'hC;
    localparam logic [3:0] KEY_BKSP = 4'hD;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational single-digit BCD adder.
//   a, b  - BCD digits (0..9)
//   cin   - carry in
//   s     - BCD sum digit
//   cout  - decimal carry out
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] raw;

    assign raw = {1'b0, a} + {1'b0, b} + {4'b0, cin};

    always_comb begin
        s    = raw[3:0];
        cout = 1'b0;
        if (raw > 5'd9) begin
            // raw - 10 modulo 16 equals raw[3:0] + 6 for raw in 10..19
            s    = raw[3:0] + 4'd6;
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/sumador_control.sv
// sumador_control: keypad-to-adder sequencing controller.
// Collects two BCD operands from keypad events, then adds them one digit
// per clock using a single bcd_digit_add.
//   clk, rst      - clock, synchronous active-low reset
//   key_code      - keypad code, valid while key_pressed=1
//   key_pressed   - level, high while a key is held (rising edge = event)
//   digits_a/b    - BCD operands, digit 0 in [3:0]
//   result        - BCD sum, NDIG+1 digits
//   result_valid  - sum is final
//   busy          - addition in progress
//   disp_sel      - 0 show A, 1 show B, 2 show result
//   state_o       - current state encoding
// Optional feature macro: SUMADOR_BACKSPACE_EN (key D deletes last digit).
module sumador_control
    import sumador_pkg::*;
#(
    parameter int NDIG = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            key_code,
    input  logic                  key_pressed,
    output logic [4*NDIG-1:0]     digits_a,
    output logic [4*NDIG-1:0]     digits_b,
    output logic [4*(NDIG+1)-1:0] result,
    output logic                  result_valid,
    output logic                  busy,
    output logic [1:0]            disp_sel,
    output logic [1:0]            state_o
);

    localparam int         W      = 4 * NDIG;
    localparam int         RW     = 4 * (NDIG + 1);
    localparam logic [3:0] NDIG_C = 4'(NDIG);

    state_t          state, state_n;
    logic            key_q;
    logic [W-1:0]    a, a_n, b, b_n;
    logic [RW-1:0]   res, res_n;
    logic            valid, valid_n;
    logic [3:0]      cnt_a, cnt_a_n, cnt_b, cnt_b_n;
    logic [3:0]      idx, idx_n;
    logic            carry, carry_n;
    logic            key_evt, clr, load_first;
    logic [3:0]      sum_dig;
    logic            sum_cout;

    assign key_evt = key_pressed & ~key_q;

    bcd_digit_add u_add (
        .a    (a[4*int'(idx) +: 4]),
        .b    (b[4*int'(idx) +: 4]),
        .cin  (carry),
        .s    (sum_dig),
        .cout (sum_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ENTER_A;
            key_q <= 1'b0;
            a     <= '0;
            b     <= '0;
            res   <= '0;
            valid <= 1'b0;
            cnt_a <= '0;
            cnt_b <= '0;
            idx   <= '0;
            carry <= 1'b0;
        end else begin
            state <= state_n;
            key_q <= key_pressed;
            a     <= a_n;
            b     <= b_n;
            res   <= res_n;
            valid <= valid_n;
            cnt_a <= cnt_a_n;
            cnt_b <= cnt_b_n;
            idx   <= idx_n;
            carry <= carry_n;
        end
    end

    always_comb begin
        state_n    = state;
        a_n        = a;
        b_n        = b;
        res_n      = res;
        valid_n    = valid;
        cnt_a_n    = cnt_a;
        cnt_b_n    = cnt_b;
        idx_n      = idx;
        carry_n    = carry;
        clr        = 1'b0;
        load_first = 1'b0;

        case (state)
            ENTER_A: begin
                if (key_evt) begin
                    if (is_digit(key_code)) begin
                        if (!(cnt_a == 4'd0 && key_code == 4'd0) && cnt_a < NDIG_C) begin
                            a_n     = (a << 4) | W'(key_code);
                            cnt_a_n = cnt_a + 4'd1;
                        end
                    end else if (key_code == KEY_ADD) begin
                        state_n = ENTER_B;
                    end else if (key_code == KEY_CLR) begin
                        clr = 1'b1;
`ifdef SUMADOR_BACKSPACE_EN
                    end else if (key_code == KEY_BKSP && cnt_a != 4'd0) begin
                        a_n     = a >> 4;
                        cnt_a_n = cnt_a - 4'd1;
`endif
                    end
                end
            end
            ENTER_B: begin
                if (key_evt) begin
                    if (is_digit(key_code)) begin
                        if (!(cnt_b == 4'd0 && key_code == 4'd0) && cnt_b < NDIG_C) begin
                            b_n     = (b << 4) | W'(key_code);
                            cnt_b_n = cnt_b + 4'd1;
                        end
                    end else if (key_code == KEY_EQ) begin
                        state_n = CALC;
                        idx_n   = '0;
                        carry_n = 1'b0;
                    end else if (key_code == KEY_CLR) begin
                        clr = 1'b1;
`ifdef SUMADOR_BACKSPACE_EN
                    end else if (key_code == KEY_BKSP && cnt_b != 4'd0) begin
                        b_n     = b >> 4;
                        cnt_b_n = cnt_b - 4'd1;
`endif
                    end
                end
            end
            CALC: begin
                res_n[4*int'(idx) +: 4] = sum_dig;
                carry_n = sum_cout;
                idx_n   = idx + 4'd1;
                // Last digit: the carry lands directly in the top result digit
                // on the same edge, so RESULT follows NDIG CALC cycles.
                if (idx == NDIG_C - 4'd1) begin
                    res_n[RW-4 +: 4] = {3'b0, sum_cout};
                    state_n          = RESULT;
                    valid_n          = 1'b1;
                    idx_n            = '0;
                end
            end
            RESULT: begin
                if (key_evt) begin
                    if (is_digit(key_code)) begin
                        clr        = 1'b1;
                        load_first = (key_code != 4'd0);
                    end else if (key_code == KEY_CLR) begin
                        clr = 1'b1;
                    end
                end
            end
            default: state_n = ENTER_A;
        endcase

        if (clr) begin
            state_n = ENTER_A;
            a_n     = '0;
            b_n     = '0;
            res_n   = '0;
            valid_n = 1'b0;
            cnt_a_n = '0;
            cnt_b_n = '0;
            idx_n   = '0;
            carry_n = 1'b0;
        end
        if (load_first) begin
            a_n     = W'(key_code);
            cnt_a_n = 4'd1;
        end
    end

    assign digits_a     = a;
    assign digits_b     = b;
    assign result       = res;
    assign result_valid = valid;
    assign busy         = (state == CALC);
    assign state_o      = state;

    always_comb begin
        disp_sel = 2'd0;
        case (state)
            ENTER_A: disp_sel = 2'd0;
            ENTER_B: disp_sel = 2'd1;
            CALC:    disp_sel = 2'd1;
            RESULT:  disp_sel = 2'd2;
            default: disp_sel = 2'd0;
        endcase
    end

endmodule
